gpr_scoreboard: RTL

Register scoreboard that sequences issue from the Decode stage into the pipeline. It tracks which GPRs have a pending write from a long-latency operation (load, multiply, divide) and stalls Decode on RAW/WAW hazards against them. It caps the number of long ops in flight. It sits beside the decode unit, taking Decode register addresses and Writeback completions, and drives the Decode stall.

---
 rtl/core_pkg.sv | 10 +
 rtl/gpr_scoreboard_if.sv | 33 +++
 rtl/sat_counter.sv | 19 +
 rtl/gpr_scoreboard.sv | 75 +++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-file size and register address type.
package core_pkg;

  localparam int unsigned NREG = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t X0 = 5'd0;

endpackage

// File: rtl/gpr_scoreboard_if.sv
// Decode/Writeback handshake between the decode unit and the register scoreboard.
interface gpr_scoreboard_if;
  import core_pkg::*;

  logic      D_valid;
  reg_addr_t D_rs1_addr;
  reg_addr_t D_rs2_addr;
  logic      D_rs1_used;
  logic      D_rs2_used;
  reg_addr_t D_rd_addr;
  logic      D_rd_wen;
  logic      D_long;
  logic      E_flush;
  reg_addr_t W_rd_addr;
  logic      W_gpr_wen;
  logic      W_long;
  logic      D_stall;

  modport master (
    output D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
    output D_rd_addr, D_rd_wen, D_long, E_flush,
    output W_rd_addr, W_gpr_wen, W_long,
    input  D_stall
  );

  modport slave (
    input  D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
    input  D_rd_addr, D_rd_wen, D_long, E_flush,
    input  W_rd_addr, W_gpr_wen, W_long,
    output D_stall
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gpr_scoreboard.sv
// GPR scoreboard: tracks pending long-latency writes and stalls Decode on
// RAW/WAW hazards or when the long-op budget is exhausted.
module gpr_scoreboard #(
  parameter  int unsigned NREG    = core_pkg::NREG,
  parameter  int unsigned MAX_OUT = 4,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  gpr_scoreboard_if.slave      sb,
  output logic [NREG-1:0]      busy,
  output logic [OUT_W-1:0]     outstanding,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 err
);
  import core_pkg::*;

  logic raw1, raw2, waw, full, stall, issue;
  logic set, clr_req, clr_hit, same, inc, dec;
  logic [NREG-1:0]  busy_d;
  logic [OUT_W-1:0] out_d;

  // Hazard detection and issue qualification
  always_comb begin
    raw1    = sb.D_rs1_used & busy[sb.D_rs1_addr];
    raw2    = sb.D_rs2_used & busy[sb.D_rs2_addr];
    waw     = sb.D_rd_wen & busy[sb.D_rd_addr];
    full    = sb.D_long & sb.D_rd_wen & (outstanding == OUT_W'(MAX_OUT));
    stall   = sb.D_valid & ~sb.E_flush & (raw1 | raw2 | waw | full);
    issue   = sb.D_valid & ~sb.E_flush & ~stall;
    set     = issue & sb.D_long & sb.D_rd_wen & (sb.D_rd_addr != X0);
    clr_req = sb.W_gpr_wen & sb.W_long & (sb.W_rd_addr != X0);
    clr_hit = clr_req & busy[sb.W_rd_addr];
    same    = set & clr_req & (sb.W_rd_addr == sb.D_rd_addr);
    inc     = set & ~same;
    dec     = clr_hit & ~same;
  end

  assign sb.D_stall = stall;

  // Next busy vector and outstanding count; a set overrides a same-register clear
  always_comb begin
    busy_d = busy;
    out_d  = outstanding;
    if (clr_hit) busy_d[sb.W_rd_addr] = 1'b0;
    if (set)     busy_d[sb.D_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
    case ({inc, dec})
      2'b10:   out_d = outstanding + OUT_W'(1);
      2'b01:   out_d = outstanding - OUT_W'(1);
      default: out_d = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      busy        <= busy_d;
      outstanding <= out_d;
      err         <= err | (clr_req & ~busy[sb.W_rd_addr]);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

endmodule
